// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch/M-op funct3 codes,
// result-source and forwarding selects, and the multiply/divide FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        RS_ALU = 2'b00,
        RS_MEM = 2'b01,
        RS_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RD = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/execute_stage_xm_md.sv
// Iterative RV32M unit: XLEN-step shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up on the way out, special divides skip RUN.
module md_unit_iter
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] md_result,
    output logic            md_done
);

    localparam int unsigned CW = $clog2(XLEN);

    md_state_e       state, state_nx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hi, lo, opnd;
    logic [XLEN-1:0] hi_nx, lo_nx;
    logic [2:0]      op_q;
    logic            neg_q, neg_r;

    logic            is_div, a_signed, b_signed, neg_a, neg_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, min_val;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        min_val  = {1'b1, {(XLEN-1){1'b0}}};
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3 != MD_MULHU);
        b_signed = is_div ? ~funct3[0] : (funct3 == MD_MUL || funct3 == MD_MULH);
        neg_a    = a_signed & op_a[XLEN-1];
        neg_b    = b_signed & op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        div_zero = is_div & (op_b == '0);
        div_ovf  = is_div & ~funct3[0] & (op_a == min_val) & (op_b == '1);
        special  = div_zero | div_ovf;
    end

    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (start) state_nx = special ? MD_DONE : MD_RUN;
            MD_RUN:  if (count == '0) state_nx = MD_DONE;
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
    end

    // hi:lo is the product accumulator for multiply, remainder:quotient for divide
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_q[2]) begin
            if (div_diff[XLEN]) begin
                hi_nx = div_shift[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b0};
            end else begin
                hi_nx = div_diff[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= MD_IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= MD_IDLE;
        end else if (!stall) begin
            state <= state_nx;
            case (state)
                MD_IDLE: if (start) begin
                    op_q  <= funct3;
                    count <= CW'(XLEN - 1);
                    // special divides preload the final answer with no sign fix
                    if (div_zero) begin
                        hi    <= op_a;
                        lo    <= '1;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (div_ovf) begin
                        hi    <= '0;
                        lo    <= min_val;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (is_div) begin
                        hi    <= '0;
                        lo    <= mag_a;
                        opnd  <= mag_b;
                        neg_q <= neg_a ^ neg_b;
                        neg_r <= neg_a;
                    end else begin
                        hi    <= '0;
                        lo    <= mag_b;
                        opnd  <= mag_a;
                        neg_q <= neg_a ^ neg_b;
                        neg_r <= 1'b0;
                    end
                end
                MD_RUN: begin
                    hi <= hi_nx;
                    lo <= lo_nx;
                    if (count != '0) count <= count - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prod     = {hi, lo};
        prod_fix = neg_q ? -prod : prod;
        case (op_q)
            MD_MUL:                       md_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              md_result = neg_q ? -lo : lo;
            default:                      md_result = neg_r ? -hi : hi;
        endcase
        md_done = (state == MD_DONE);
    end

endmodule

// File: rtl/execute_stage_xm.sv
// Execute stage: operand forwarding, RV32I ALU, branch/jump resolution,
// iterative RV32M unit with stall handshake, and the E/M pipeline register.
module execute_stage_xm
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [RAW-1:0]  RDE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [3:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [2:0]      Funct3E,
    input  logic            MdEnE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [RAW-1:0]  RDM,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            MdBusyE
);

    localparam int unsigned SW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, md_result, jalr_sum;
    logic [SW-1:0]   shamt;
    logic            br_taken, md_done, md_busy;

    always_comb begin
        case (ForwardAE)
            FWD_W:   src_a = ResultW;
            FWD_M:   src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            FWD_W:   fwd_b = ResultW;
            FWD_M:   fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
        src_b = ALUSrcE ? ImmExtE : fwd_b;
        shamt = src_b[SW-1:0];
    end

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
            default:  alu_result = '0;
        endcase
    end

    // branches compare rs1 against forwarded rs2, never the immediate
    always_comb begin
        br_taken = 1'b0;
        case (Funct3E)
            BR_EQ:   br_taken = (src_a == fwd_b);
            BR_NE:   br_taken = (src_a != fwd_b);
            BR_LT:   br_taken = ($signed(src_a) < $signed(fwd_b));
            BR_GE:   br_taken = ($signed(src_a) >= $signed(fwd_b));
            BR_LTU:  br_taken = (src_a < fwd_b);
            BR_GEU:  br_taken = (src_a >= fwd_b);
            default: br_taken = 1'b0;
        endcase
        jalr_sum  = src_a + ImmExtE;
        PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
        PCSrcE    = ~flush_i & (JumpE | JalrE | (BranchE & br_taken));
    end

    md_unit_iter #(
        .XLEN(XLEN)
    ) u_md (
        .clk       (clk),
        .rst       (rst),
        .start     (MdEnE),
        .stall     (stall_i),
        .flush     (flush_i),
        .funct3    (Funct3E),
        .op_a      (src_a),
        .op_b      (fwd_b),
        .md_result (md_result),
        .md_done   (md_done)
    );

    assign md_busy = MdEnE & ~md_done;
    assign MdBusyE = md_busy;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= RS_ALU;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RDM        <= '0;
        end else if (!stall_i) begin
            RegWriteM  <= RegWriteE & ~md_busy;
            MemWriteM  <= MemWriteE & ~md_busy;
            ResultSrcM <= md_busy ? RS_ALU : ResultSrcE;
            ALUResultM <= MdEnE ? md_result : alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
            RDM        <= RDE;
        end
    end

endmodule

// File: tb/tb_execute_stage_xm.sv
// Randomized bench for execute_stage_xm against an arithmetic reference model.
module tb_execute_stage_xm;

    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RDE;
    logic [1:0]  ForwardAE, ForwardBE, ResultSrcE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE, BranchE, JumpE, JalrE, MdEnE, RegWriteE, MemWriteE;
    logic [2:0]  Funct3E;
    logic        RegWriteM, MemWriteM, PCSrcE, MdBusyE;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
    logic [4:0]  RDM;

    int unsigned n_vec = 0, n_bad = 0;
    int          last_busy;
    logic [31:0] m_alum;
    logic [4:0]  m_rd;
    logic        m_rw, m_known;

    always #5 clk = ~clk;

    execute_stage_xm #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ResultW(ResultW), .RDE(RDE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .JalrE(JalrE), .Funct3E(Funct3E), .MdEnE(MdEnE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RDM(RDM), .PCTargetE(PCTargetE),
        .PCSrcE(PCSrcE), .MdBusyE(MdBusyE)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic md_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] m_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (f3)
            3'b000: begin p = 64'(sa * sb); return p[31:0];  end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
        case (sel)
            2'b01:   return ResultW;
            2'b10:   return m_alum;
            default: return rd;
        endcase
    endfunction

    task automatic clear_ctrl();
        BranchE = 0; JumpE = 0; JalrE = 0; MdEnE = 0; ALUSrcE = 0;
        stall_i = 0; flush_i = 0; MemWriteE = 0; ResultSrcE = 0; RegWriteE = 1;
        ForwardAE = 0; ForwardBE = 0;
    endtask

    // entry and exit at posedge+1
    task automatic step_alu();
        logic [31:0] a, bf, b, e_alu, e_tgt, e_pc4;
        logic        e_src, e_rw, e_mw;
        logic [1:0]  e_rs;
        logic [4:0]  e_rd;
        if (!m_known) begin
            if (ForwardAE == 2'b10) ForwardAE = 2'b00;
            if (ForwardBE == 2'b10) ForwardBE = 2'b00;
        end
        a     = fwd(ForwardAE, RD1E);
        bf    = fwd(ForwardBE, RD2E);
        b     = ALUSrcE ? ImmExtE : bf;
        e_alu = m_alu(ALUControlE, a, b);
        e_tgt = JalrE ? ((a + ImmExtE) & 32'hFFFF_FFFE) : (PCE + ImmExtE);
        e_src = JumpE | JalrE | (BranchE & m_cond(Funct3E, a, bf));
        e_pc4 = PCPlus4E; e_rd = RDE; e_rw = RegWriteE; e_mw = MemWriteE; e_rs = ResultSrcE;
        #1;
        chk("pc_target", PCTargetE, e_tgt);
        chk("pc_src", 32'(PCSrcE), 32'(e_src));
        chk("busy_alu", 32'(MdBusyE), 32'd0);
        @(posedge clk); #1;
        chk("alu_result", ALUResultM, e_alu);
        chk("write_data", WriteDataM, bf);
        chk("pc_plus4", PCPlus4M, e_pc4);
        chk("rd", 32'(RDM), 32'(e_rd));
        chk("reg_write", 32'(RegWriteM), 32'(e_rw));
        chk("mem_write", 32'(MemWriteM), 32'(e_mw));
        chk("result_src", 32'(ResultSrcM), 32'(e_rs));
        m_alum = e_alu; m_rd = e_rd; m_rw = e_rw; m_known = 1;
    endtask

    task automatic rand_alu();
        clear_ctrl();
        RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        ImmExtE = $urandom; PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
        RDE = 5'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        ALUControlE = 4'($urandom); ALUSrcE = 1'($urandom); BranchE = 1'($urandom);
        JumpE = ($urandom_range(0, 3) == 0); JalrE = ($urandom_range(0, 3) == 0);
        Funct3E = 3'($urandom); RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
        ResultSrcE = 2'($urandom);
        step_alu();
    endtask

    task automatic stall_hold();
        RD1E = $urandom; RDE = 5'($urandom); RegWriteE = ~m_rw; ALUControlE = 4'($urandom);
        stall_i = 1;
        @(posedge clk); #1;
        chk("stall_alu", ALUResultM, m_alum);
        chk("stall_rd", 32'(RDM), 32'(m_rd));
        chk("stall_rw", 32'(RegWriteM), 32'(m_rw));
        stall_i = 0;
    endtask

    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_res;
        int          e_busy, cnt;
        logic [4:0]  e_rd;
        e_res  = m_md(f3, a, b);
        e_busy = md_special(f3, a, b) ? 1 : XLEN + 1;
        clear_ctrl();
        MdEnE = 1; Funct3E = f3; RD1E = a; RD2E = b; RDE = 5'($urandom); e_rd = RDE;
        ALUControlE = 4'($urandom); ALUSrcE = 1'($urandom); ImmExtE = $urandom;
        PCPlus4E = $urandom; ResultSrcE = 2'($urandom);
        cnt = 0;
        for (int i = 0; i < XLEN + 6; i++) begin
            #1;
            if (!MdBusyE) break;
            cnt++;
            @(posedge clk); #1;
            chk("md_bubble_rw", 32'(RegWriteM), 32'd0);
            chk("md_bubble_rs", 32'(ResultSrcM), 32'd0);
            RD1E = $urandom; RD2E = $urandom;
        end
        @(posedge clk); #1;
        last_busy = cnt;
        chk("md_busy_cycles", 32'(cnt), 32'(e_busy));
        chk("md_result", ALUResultM, e_res);
        chk("md_commit_rw", 32'(RegWriteM), 32'd1);
        chk("md_commit_rd", 32'(RDM), 32'(e_rd));
        m_alum = e_res; m_rd = e_rd; m_rw = 1; m_known = 1;
        MdEnE = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f3;
        clear_ctrl();
        rst = 0; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
        RDE = 0; ALUControlE = 0; Funct3E = 0; m_known = 0; last_busy = 0;
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu", ALUResultM, 32'd0);
        chk("rst_rw", 32'(RegWriteM), 32'd0);
        chk("rst_mw", 32'(MemWriteM), 32'd0);
        chk("rst_rs", 32'(ResultSrcM), 32'd0);
        chk("rst_wd", WriteDataM, 32'd0);
        chk("rst_rd", 32'(RDM), 32'd0);
        m_alum = 0; m_rd = 0; m_rw = 0; m_known = 1;
        rst = 1;

        // add with M-stage forwarding
        clear_ctrl(); RD1E = 5; RD2E = 2; ALUControlE = 0; RDE = 3; PCPlus4E = 32'h44;
        step_alu();
        RD1E = 32'hDEAD; ForwardAE = 2'b10; ImmExtE = 32'hFFFF_FFFD; ALUSrcE = 1;
        step_alu();
        chk("add_fwd", ALUResultM, 32'd4);
        chk("add_fwd_rw", 32'(RegWriteM), 32'd1);

        // blt / bltu
        clear_ctrl(); RD1E = 32'hFFFF_FFFF; RD2E = 1; BranchE = 1; Funct3E = 3'b100;
        PCE = 32'h100; ImmExtE = 32'h20; RegWriteE = 0; ALUControlE = 1;
        #1; chk("blt_src", 32'(PCSrcE), 32'd1); chk("blt_tgt", PCTargetE, 32'h120);
        step_alu();
        Funct3E = 3'b110;
        #1; chk("bltu_src", 32'(PCSrcE), 32'd0);
        step_alu();

        // jalr
        clear_ctrl(); JalrE = 1; RD1E = 32'h1003; ImmExtE = 4; ALUSrcE = 1; ResultSrcE = 2'b10;
        #1; chk("jalr_tgt", PCTargetE, 32'h1006);
        step_alu();
        chk("jalr_rs", 32'(ResultSrcM), 32'd2);

        // M directed
        run_md(3'b100, 32'hFFFF_FFF9, 32'd2);
        chk("div_res", ALUResultM, 32'hFFFF_FFFD); chk("div_busy", 32'(last_busy), 32'd33);
        run_md(3'b110, 32'hFFFF_FFF9, 32'd2);
        chk("rem_res", ALUResultM, 32'hFFFF_FFFF);
        run_md(3'b001, 32'h8000_0000, 32'h8000_0000);
        chk("mulh_res", ALUResultM, 32'h4000_0000);
        run_md(3'b101, 32'h1234, 32'd0);
        chk("divu0_res", ALUResultM, 32'hFFFF_FFFF); chk("divu0_busy", 32'(last_busy), 32'd1);
        run_md(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_div", ALUResultM, 32'h8000_0000);
        run_md(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_rem", ALUResultM, 32'd0);

        for (int n = 0; n < 150; n++) begin
            rand_alu();
            if ($urandom_range(0, 7) == 0) stall_hold();
        end

        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom); a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 5) - 2; end
                default: ;
            endcase
            run_md(f3, a, b);
            rand_alu();
        end

        // flush in RUN cycle 10 aborts the op
        clear_ctrl(); MdEnE = 1; Funct3E = 3'b100; RD1E = 32'd1000; RD2E = 32'd7; RDE = 9;
        repeat (11) @(posedge clk);
        #1;
        flush_i = 1; JumpE = 1;
        #1; chk("flush_pcsrc", 32'(PCSrcE), 32'd0);
        @(posedge clk); #1;
        flush_i = 0; JumpE = 0; MdEnE = 0;
        chk("flush_rw", 32'(RegWriteM), 32'd0);
        chk("flush_mw", 32'(MemWriteM), 32'd0);
        m_known = 0; m_rw = 0;
        run_md(3'b101, 32'd100, 32'd9);

        // reset mid-op
        clear_ctrl(); MdEnE = 1; Funct3E = 3'b000; RD1E = 32'd12345; RD2E = 32'd678;
        MemWriteE = 1; ResultSrcE = 2'b01; PCPlus4E = 32'h88; RDE = 7;
        repeat (5) @(posedge clk);
        #1; rst = 0;
        @(posedge clk); #1;
        chk("rstmid_alu", ALUResultM, 32'd0);
        chk("rstmid_rw", 32'(RegWriteM), 32'd0);
        chk("rstmid_mw", 32'(MemWriteM), 32'd0);
        chk("rstmid_rs", 32'(ResultSrcM), 32'd0);
        chk("rstmid_pc4", PCPlus4M, 32'd0);
        chk("rstmid_rd", 32'(RDM), 32'd0);
        rst = 1; MdEnE = 0;
        m_alum = 0; m_rd = 0; m_rw = 0; m_known = 1;
        run_md(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rand_alu();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_stage_xm.md
# execute_stage_xm

Parametrised execute stage for the 5-stage RISC-V pipeline: forwarding muxes, full RV32I ALU, all six branch conditions plus JAL/JALR target generation, and an iterative RV32M multiply/divide unit with stall handshake. Feeds the E/M pipeline register with stall and flush control. Sits between decode/hazard logic and the memory stage.

## Interface
- XLEN, 32, datapath width (power of two, at least 8)
- RAW, 5, register-address width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- stall_i / flush_i  in  1  hold / bubble the E/M register (flush wins)
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW  in  XLEN  operands, immediate, PCs, writeback forward value
- RDE  in  RAW  destination register
- ForwardAE, ForwardBE  in  2  00 RD, 01 ResultW, 10 ALUResultM, 11 RD
- ALUControlE  in  4  ALU op (package encoding)
- ALUSrcE  in  1  0 forwarded B, 1 ImmExtE
- BranchE, JumpE, JalrE  in  1  branch, JAL, JALR
- Funct3E  in  3  branch condition or M-op select
- MdEnE  in  1  instruction is an RV32M op
- RegWriteE, MemWriteE  in  1  controls
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4
- RegWriteM, MemWriteM  out  1  registered controls
- ResultSrcM  out  2  registered
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered
- RDM  out  RAW  registered
- PCTargetE  out  XLEN  combinational branch/jump target
- PCSrcE  out  1  combinational redirect
- MdBusyE  out  1  combinational; hazard unit must stall F/D and hold E while high

## Operation
- ALU ops: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra; 10-15 yield 0. Shift amount = low log2(XLEN) bits of B.
- WriteDataM captures the forwarded B value (pre-ALUSrc mux), not RD2E.
- Branch cond by Funct3E: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; others false.
- PCTargetE = JalrE ? (SrcA+Imm) with bit0 cleared : PCE+Imm. PCSrcE = JumpE | JalrE | (BranchE & cond); forced 0 while flush_i.
- M ops by Funct3E: mul, mulh, mulhsu, mulhu, div, divu, rem, remu. Multiply: XLEN-step shift-add on magnitudes, sign fix at end. Divide: XLEN-step restoring.
- Div by zero: quotient all ones, remainder = dividend. Signed overflow (min / -1): quotient = min, remainder 0. Both resolve with no RUN cycles.
- FSM: IDLE -> (MdEnE, not special) RUN, counter = XLEN-1; RUN decrements each cycle, at 0 -> DONE; special case IDLE -> DONE directly; DONE -> IDLE. Operands captured on leaving IDLE; later forwarding changes ignored.
- MdBusyE = MdEnE & (state != DONE). While busy the E/M register loads a bubble (RegWrite, MemWrite = 0; ResultSrc 00). In DONE the M result replaces ALUResultE and the instruction commits normally.
- stall_i: E/M register and FSM hold. flush_i: E/M controls zeroed, FSM -> IDLE (aborts M op), data fields don't-care.

## Timing
- Reset: all registered outputs 0, FSM IDLE, counter 0. Reset mid-M-op aborts it.
- ALU/branch: result in ALUResultM one cycle after issue; PCTargetE/PCSrcE same cycle.
- M op: MdBusyE high XLEN+1 cycles (1 for special cases); result registered at end of DONE cycle, i.e. ALUResultM valid XLEN+2 cycles after first presentation (2 for special).
- Back-to-back M ops: second op sees IDLE the cycle after DONE; no dead cycle beyond that.

## Structure
- Package exec_pkg: ALU op codes, branch and M funct3 codes, ResultSrc codes, FSM state enum.
- Sub-module md_unit_iter: FSM, counter, shift-add/restoring datapath, special-case detection; outputs md_result and md_done.

## Test plan
- add 7+(-3) with ForwardAE=10, ALUResultM=7 -> ALUResultM=4 next cycle, RegWriteM=1.
- blt 0xFFFFFFFF vs 1, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120; bltu same operands -> PCSrcE=0.
- jalr, SrcA=0x1003, Imm=4 -> PCTargetE=0x1006, ResultSrcM=10.
- div -7/2 -> MdBusyE high 33 cycles, then ALUResultM=-3; rem -> -1; mulh 0x80000000*0x80000000 -> 0x40000000.
- divu by 0 -> busy 1 cycle, result 0xFFFFFFFF; div 0x80000000 / -1 -> 0x80000000, rem 0.
- flush_i at RUN cycle 10 -> FSM IDLE, RegWriteM=0; rst low mid-op -> all outputs 0 next edge.
